// File: rtl/controle_multiciclo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : controle_multiciclo_pkg
//  Description : Shared constants for the multicycle control unit: FSM state
//                encodings, supported opcodes, branch funct3 codes and small
//                decode helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package controle_multiciclo_pkg;

   // FSM state encodings (the instruction memory latches on ST_BUSCA)
   localparam logic [3:0] ST_BUSCA      = 4'b0000;
   localparam logic [3:0] ST_DECODIFICA = 4'b0001;
   localparam logic [3:0] ST_EXECUTA    = 4'b0010;
   localparam logic [3:0] ST_MEMORIA    = 4'b0011;
   localparam logic [3:0] ST_ESCRITA    = 4'b0100;
   localparam logic [3:0] ST_FIM        = 4'b1111;

   // Supported opcodes
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I_ALU  = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   // Branch conditions that can be taken
   localparam logic [2:0] F3_BEQ = 3'b000;
   localparam logic [2:0] F3_BNE = 3'b001;

   // Anything outside the five supported opcodes is retired as a NOP
   function automatic logic opcode_valido(input logic [6:0] op);
      return (op == OP_R)     || (op == OP_I_ALU) || (op == OP_LOAD) ||
             (op == OP_STORE) || (op == OP_BRANCH);
   endfunction

   // Only BEQ and BNE can be taken; every other funct3 falls through
   function automatic logic desvio_tomado(input logic [2:0] f3, input logic z);
      return ((f3 == F3_BEQ) && z) || ((f3 == F3_BNE) && !z);
   endfunction

endpackage : controle_multiciclo_pkg
`default_nettype wire

// File: rtl/controle_multiciclo_imediato_desvio.sv
`default_nettype none
// ============================================================================
//  Module      : imediato_desvio
//  Description : Extracts the B-type immediate from an instruction word and
//                sign-extends it to 32 bits (bit 0 is always zero).
//  Revision    : 1.0 - initial release
// ============================================================================
module imediato_desvio (
   input  logic [31:0] instrucao_i,
   output logic [31:0] imediato_o
);

   logic [12:0] w_imm13;
   logic        w_unused_campos;

   // imm[12|10:5] come from bits 31:25, imm[4:1|11] from bits 11:7
   assign w_imm13 = {instrucao_i[31], instrucao_i[7], instrucao_i[30:25],
                     instrucao_i[11:8], 1'b0};

   assign imediato_o = {{19{w_imm13[12]}}, w_imm13};

   // opcode, funct3 and register fields are decoded elsewhere
   assign w_unused_campos = ^{instrucao_i[24:12], instrucao_i[6:0]};

endmodule : imediato_desvio
`default_nettype wire

// File: rtl/controle_multiciclo.sv
`default_nettype none
// ============================================================================
//  Module      : controle_multiciclo
//  Description : Multicycle control FSM. Fetches, decodes and sequences
//                R/I-ALU, load, store and branch instructions, generates the
//                datapath strobes and counts retired instructions. The PC is
//                a word index; leaving the program range parks the FSM in FIM.
//  Revision    : 1.0 - initial release
// ============================================================================
module controle_multiciclo
   import controle_multiciclo_pkg::*;
#(
   parameter int unsigned N_INSTR = 9
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [31:0] instrucao,
   input  logic        zero,
   output logic [31:0] PC,
   output logic [3:0]  estado,
   output logic        escreve_reg,
   output logic        le_mem,
   output logic        escreve_mem,
   output logic        fim,
   output logic [31:0] instr_retiradas
);

   localparam logic [31:0] C_LIMITE_PC = 32'(N_INSTR);

   logic [3:0]  estado_q, estado_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] cont_q, cont_d;
   logic [6:0]  opcode_q, opcode_d;
   logic [2:0]  funct3_q, funct3_d;
   logic [31:0] imm_q, imm_d;

   logic [31:0] w_imm_instr;
   logic [31:0] w_desloc;
   logic [31:0] w_pc_prox;
   logic        w_retira;

   imediato_desvio u_imediato_desvio (
      .instrucao_i (instrucao),
      .imediato_o  (w_imm_instr)
   );

   // Immediate is a byte offset; PC counts words, hence the arithmetic shift
   assign w_desloc = 32'($signed(imm_q) >>> 2);

   // Next-state, next-PC and retire decision
   always_comb begin
      estado_d  = estado_q;
      pc_d      = pc_q;
      cont_d    = cont_q;
      opcode_d  = opcode_q;
      funct3_d  = funct3_q;
      imm_d     = imm_q;
      w_retira  = 1'b0;
      w_pc_prox = pc_q + 32'd1;

      case (estado_q)
         ST_BUSCA: begin
            estado_d = ST_DECODIFICA;
         end
         ST_DECODIFICA: begin
            opcode_d = instrucao[6:0];
            funct3_d = instrucao[14:12];
            imm_d    = w_imm_instr;
            if (opcode_valido(instrucao[6:0])) begin
               estado_d = ST_EXECUTA;
            end else begin
               w_retira = 1'b1;
            end
         end
         ST_EXECUTA: begin
            case (opcode_q)
               OP_R, OP_I_ALU:    estado_d = ST_ESCRITA;
               OP_LOAD, OP_STORE: estado_d = ST_MEMORIA;
               OP_BRANCH: begin
                  w_retira = 1'b1;
                  if (desvio_tomado(funct3_q, zero)) begin
                     w_pc_prox = pc_q + w_desloc;
                  end
               end
               // Unreachable: only valid opcodes enter EXECUTA
               default:           w_retira = 1'b1;
            endcase
         end
         ST_MEMORIA: begin
            if (opcode_q == OP_LOAD) begin
               estado_d = ST_ESCRITA;
            end else begin
               w_retira = 1'b1;
            end
         end
         ST_ESCRITA: begin
            w_retira = 1'b1;
         end
         ST_FIM: begin
            estado_d = ST_FIM;
         end
         // Unused encodings recover by refetching the current PC
         default: begin
            estado_d = ST_BUSCA;
         end
      endcase

      // A negative target wraps to a huge unsigned value and also ends here
      if (w_retira) begin
         pc_d     = w_pc_prox;
         cont_d   = cont_q + 32'd1;
         estado_d = (w_pc_prox < C_LIMITE_PC) ? ST_BUSCA : ST_FIM;
      end
   end

   // State, PC, counter and latched instruction fields
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         estado_q <= ST_BUSCA;
         pc_q     <= 32'd0;
         cont_q   <= 32'd0;
         opcode_q <= 7'd0;
         funct3_q <= 3'd0;
         imm_q    <= 32'd0;
      end else begin
         estado_q <= estado_d;
         pc_q     <= pc_d;
         cont_q   <= cont_d;
         opcode_q <= opcode_d;
         funct3_q <= funct3_d;
         imm_q    <= imm_d;
      end
   end

   // Moore outputs: decoded from the registered state and latched opcode
   assign PC              = pc_q;
   assign estado          = estado_q;
   assign instr_retiradas = cont_q;
   assign fim             = (estado_q == ST_FIM);
   assign escreve_reg     = (estado_q == ST_ESCRITA);
   assign le_mem          = (estado_q == ST_MEMORIA) && (opcode_q == OP_LOAD);
   assign escreve_mem     = (estado_q == ST_MEMORIA) && (opcode_q == OP_STORE);

endmodule : controle_multiciclo
`default_nettype wire

// File: tb/tb_controle_multiciclo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_controle_multiciclo
//  Description : Directed testbench for controle_multiciclo. The stimulus
//                process pushes the expected post-edge observation of each
//                cycle into a queue; a monitor pops and compares it on the
//                following falling edge (or immediately after an async reset).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_controle_multiciclo;

   typedef struct packed {
      logic [3:0]  est;
      logic [31:0] pc;
      logic        er;
      logic        lm;
      logic        em;
      logic        f;
      logic [31:0] cnt;
   } obs_t;

   localparam logic [31:0] I_R     = 32'h002081B3;
   localparam logic [31:0] I_LOAD  = 32'h0000A103;
   localparam logic [31:0] I_STORE = 32'h0020A023;
   localparam logic [31:0] I_BEQP8 = 32'h00000463;
   localparam logic [31:0] I_BEQM8 = 32'hFE000CE3;
   localparam logic [31:0] I_BEQM16= 32'hFE0008E3;
   localparam logic [31:0] I_BNEP8 = 32'h00001463;
   localparam logic [31:0] I_BLTP8 = 32'h00004463;
   localparam logic [31:0] I_NOP   = 32'h00000073;

   logic        clk;
   logic        reset_n;
   logic [31:0] instrucao;
   logic        zero;
   logic [31:0] PC;
   logic [3:0]  estado;
   logic        escreve_reg;
   logic        le_mem;
   logic        escreve_mem;
   logic        fim;
   logic [31:0] instr_retiradas;

   obs_t  exp_q[$];
   string nome_q[$];
   event  chk_now;
   int    n_checks = 0;
   int    n_fail   = 0;

   controle_multiciclo #(.N_INSTR(9)) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .instrucao       (instrucao),
      .zero            (zero),
      .PC              (PC),
      .estado          (estado),
      .escreve_reg     (escreve_reg),
      .le_mem          (le_mem),
      .escreve_mem     (escreve_mem),
      .fim             (fim),
      .instr_retiradas (instr_retiradas)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic obs_t mk(input logic [3:0] est, input logic [31:0] pc,
                               input logic [31:0] cnt, input logic er,
                               input logic lm, input logic em, input logic f);
      obs_t o;
      o.est = est; o.pc = pc; o.cnt = cnt;
      o.er = er; o.lm = lm; o.em = em; o.f = f;
      return o;
   endfunction

   // Drive one cycle of inputs and queue what must be visible after the edge
   task automatic tick(input logic [31:0] ins, input logic z, input logic rn,
                       input string nm, input logic [3:0] est,
                       input logic [31:0] pc, input logic [31:0] cnt,
                       input logic er, input logic lm, input logic em,
                       input logic f);
      @(negedge clk);
      #1;
      instrucao = ins;
      zero      = z;
      reset_n   = rn;
      exp_q.push_back(mk(est, pc, cnt, er, lm, em, f));
      nome_q.push_back(nm);
   endtask

   // Assert reset between edges and require the outputs to clear at once
   task automatic reset_assincrono(input string nm);
      @(negedge clk);
      #1;
      reset_n = 1'b0;
      #1;
      exp_q.push_back(mk(4'h0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0));
      nome_q.push_back(nm);
      -> chk_now;
   endtask

   // Monitor: compare the DUT against the oldest queued expectation
   initial begin
      obs_t  e;
      obs_t  a;
      string nm;
      forever begin
         @(negedge clk or chk_now);
         if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = nome_q.pop_front();
            a  = mk(estado, PC, instr_retiradas, escreve_reg, le_mem,
                    escreve_mem, fim);
            n_checks++;
            if (a !== e) begin
               n_fail++;
               $display("FAIL %s: got estado=%h PC=%h reg/le/esc=%b%b%b fim=%b ret=%0d, expected estado=%h PC=%h reg/le/esc=%b%b%b fim=%b ret=%0d",
                        nm, a.est, a.pc, a.er, a.lm, a.em, a.f, a.cnt,
                        e.est, e.pc, e.er, e.lm, e.em, e.f, e.cnt);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion, expected finish before timeout");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset_n   = 1'b0;
      instrucao = 32'd0;
      zero      = 1'b0;

      reset_assincrono("reset_inicial");

      // R-type at PC 0: 0,1,2,4,0
      tick(I_R, 0, 1, "r_decod",   4'h1, 0, 0, 0, 0, 0, 0);
      tick(I_R, 0, 1, "r_exec",    4'h2, 0, 0, 0, 0, 0, 0);
      tick(I_R, 0, 1, "r_escrita", 4'h4, 0, 0, 1, 0, 0, 0);
      tick(I_R, 0, 1, "r_retira",  4'h0, 1, 1, 0, 0, 0, 0);

      // Load at PC 1: 0,1,2,3,4,0
      tick(I_LOAD, 0, 1, "ld_decod",   4'h1, 1, 1, 0, 0, 0, 0);
      tick(I_LOAD, 0, 1, "ld_exec",    4'h2, 1, 1, 0, 0, 0, 0);
      tick(I_LOAD, 0, 1, "ld_mem",     4'h3, 1, 1, 0, 1, 0, 0);
      tick(I_LOAD, 0, 1, "ld_escrita", 4'h4, 1, 1, 1, 0, 0, 0);
      tick(I_LOAD, 0, 1, "ld_retira",  4'h0, 2, 2, 0, 0, 0, 0);

      // beq +8 at PC 2, zero=1 -> PC 4
      tick(I_BEQP8, 1, 1, "beq_t_decod", 4'h1, 2, 2, 0, 0, 0, 0);
      tick(I_BEQP8, 1, 1, "beq_t_exec",  4'h2, 2, 2, 0, 0, 0, 0);
      tick(I_BEQP8, 1, 1, "beq_t_pc4",   4'h0, 4, 3, 0, 0, 0, 0);

      // beq -8 at PC 4, zero=1 -> PC 2 (negative, in range)
      tick(I_BEQM8, 1, 1, "beqm8_decod", 4'h1, 4, 3, 0, 0, 0, 0);
      tick(I_BEQM8, 1, 1, "beqm8_exec",  4'h2, 4, 3, 0, 0, 0, 0);
      tick(I_BEQM8, 1, 1, "beqm8_pc2",   4'h0, 2, 4, 0, 0, 0, 0);

      // beq +8 at PC 2, zero=0 -> PC 3
      tick(I_BEQP8, 0, 1, "beq_nt_decod", 4'h1, 2, 4, 0, 0, 0, 0);
      tick(I_BEQP8, 0, 1, "beq_nt_exec",  4'h2, 2, 4, 0, 0, 0, 0);
      tick(I_BEQP8, 0, 1, "beq_nt_pc3",   4'h0, 3, 5, 0, 0, 0, 0);

      // bne +8 at PC 3, zero=0 -> PC 5
      tick(I_BNEP8, 0, 1, "bne_decod", 4'h1, 3, 5, 0, 0, 0, 0);
      tick(I_BNEP8, 0, 1, "bne_exec",  4'h2, 3, 5, 0, 0, 0, 0);
      tick(I_BNEP8, 0, 1, "bne_pc5",   4'h0, 5, 6, 0, 0, 0, 0);

      // funct3=100 is never taken, even with zero=1 -> PC 6
      tick(I_BLTP8, 1, 1, "blt_decod", 4'h1, 5, 6, 0, 0, 0, 0);
      tick(I_BLTP8, 1, 1, "blt_exec",  4'h2, 5, 6, 0, 0, 0, 0);
      tick(I_BLTP8, 1, 1, "blt_pc6",   4'h0, 6, 7, 0, 0, 0, 0);

      // Store at PC 6
      tick(I_STORE, 0, 1, "st_decod",  4'h1, 6, 7, 0, 0, 0, 0);
      tick(I_STORE, 0, 1, "st_exec",   4'h2, 6, 7, 0, 0, 0, 0);
      tick(I_STORE, 0, 1, "st_mem",    4'h3, 6, 7, 0, 0, 1, 0);
      tick(I_STORE, 0, 1, "st_retira", 4'h0, 7, 8, 0, 0, 0, 0);

      // NOPs at PC 7 and PC 8; the second runs off the end into FIM
      tick(I_NOP, 0, 1, "nop7_decod", 4'h1, 7, 8, 0, 0, 0, 0);
      tick(I_NOP, 0, 1, "nop7_retira",4'h0, 8, 9, 0, 0, 0, 0);
      tick(I_NOP, 0, 1, "nop8_decod", 4'h1, 8, 9, 0, 0, 0, 0);
      tick(I_NOP, 0, 1, "nop8_fim",   4'hF, 9, 10, 0, 0, 0, 1);
      for (int i = 0; i < 20; i++) begin
         tick((i % 2 == 0) ? I_LOAD : I_R, i[0], 1, "fim_hold",
              4'hF, 9, 10, 0, 0, 0, 1);
      end

      // Reset while in FIM
      reset_assincrono("reset_em_fim");
      tick(I_NOP, 0, 0, "reset_mantido", 4'h0, 0, 0, 0, 0, 0, 0);
      tick(I_NOP, 0, 1, "pos_reset_decod", 4'h1, 0, 0, 0, 0, 0, 0);
      tick(I_NOP, 0, 1, "nop0_retira",     4'h0, 1, 1, 0, 0, 0, 0);

      // beq -16 taken at PC 1 -> wraps to 0xFFFFFFFD, FIM
      tick(I_BEQM16, 1, 1, "beqm16_decod", 4'h1, 1, 1, 0, 0, 0, 0);
      tick(I_BEQM16, 1, 1, "beqm16_exec",  4'h2, 1, 1, 0, 0, 0, 0);
      tick(I_BEQM16, 1, 1, "beqm16_fim",   4'hF, 32'hFFFF_FFFD, 2, 0, 0, 0, 1);
      for (int i = 0; i < 5; i++) begin
         tick((i % 2 == 0) ? I_STORE : I_LOAD, 0, 1, "beqm16_hold",
              4'hF, 32'hFFFF_FFFD, 2, 0, 0, 0, 1);
      end

      // Store interrupted by reset during MEMORIA
      reset_assincrono("reset_pre_store");
      tick(I_STORE, 0, 0, "reset_mantido2", 4'h0, 0, 0, 0, 0, 0, 0);
      tick(I_STORE, 0, 1, "st0_decod",      4'h1, 0, 0, 0, 0, 0, 0);
      tick(I_STORE, 0, 1, "st0_exec",       4'h2, 0, 0, 0, 0, 0, 0);
      tick(I_STORE, 0, 1, "st0_mem",        4'h3, 0, 0, 0, 0, 1, 0);
      reset_assincrono("reset_em_memoria");
      tick(I_STORE, 0, 0, "sem_escreve_mem", 4'h0, 0, 0, 0, 0, 0, 0);
      tick(I_NOP, 0, 1, "restart_decod",     4'h1, 0, 0, 0, 0, 0, 0);
      tick(I_NOP, 0, 1, "restart_retira",    4'h0, 1, 1, 0, 0, 0, 0);

      @(negedge clk);
      #2;
      if (exp_q.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL drain: got %0d pending expectations, expected 0",
                  exp_q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule : tb_controle_multiciclo
`default_nettype wire
